game_sequencer: RTL and testbench

Top-level sequencer for the coin-operated guessing game. It accepts coins into a saturating credit counter and starts a game when credit covers the cost. It fires a one-cycle master-pattern load, then runs up to MAX_ROUNDS guess/grade exchanges with the external grader and reports win or loss. It sits between the debounced front-panel inputs and the pattern register/grader datapath.

---
 rtl/game_sequencer.sv | 159 +++++++++++++++
 tb/tb_game_sequencer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// -----------------------------------------------------------------------------
// game_sequencer
//
// Top-level sequencer for the coin-operated guessing game. Coins feed a
// saturating credit counter. A start request with enough credit fires a
// one-cycle master-pattern load. Up to MAX_ROUNDS guess/grade exchanges with
// the external grader follow, and the game ends in a win or a loss.
//
// State table:
//   state      | meaning
//   WAIT_COIN  | idle; accepts a coin or a start request
//   HOLD_COIN  | coin credited; waits for the coin to be removed
//   LOAD       | loadMaster strobe cycle; the game starts here
//   WAIT_GUESS | waits for the player to submit a guess
//   GRADING    | gradeReq held high until the grader answers
//   HOLD_GRADE | waits for GradeIt to be released (one grade per press)
//   DONE       | game over; waits for GradeIt and StartGame to be low
//
// Ports:
//   clock, reset            system clock, async active-high reset
//   CoinInserted, CoinValue coin-present level and coin worth code
//   StartGame, GradeIt      player start request and guess submission
//   gradeDone, numZnarly    grader result pulse and exact-match count
//   credits                 current credit count
//   loadMaster              one-cycle strobe to latch the master pattern
//   gradeReq                request to the grader, held until gradeDone
//   roundNum                guesses completed in the current game
//   gameActive              high from LOAD through the end of the last grade
//   gameWon, gameLost       sticky result of the last game
// -----------------------------------------------------------------------------
module game_sequencer #(
  parameter int GAME_COST  = 4,
  parameter int MAX_CREDIT = 7,
  parameter int MAX_ROUNDS = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       CoinInserted,
  input  logic [1:0] CoinValue,
  input  logic       StartGame,
  input  logic       GradeIt,
  input  logic       gradeDone,
  input  logic [2:0] numZnarly,
  output logic [2:0] credits,
  output logic       loadMaster,
  output logic       gradeReq,
  output logic [3:0] roundNum,
  output logic       gameActive,
  output logic       gameWon,
  output logic       gameLost
);

  typedef enum logic [2:0] {
    WAIT_COIN,
    HOLD_COIN,
    LOAD,
    WAIT_GUESS,
    GRADING,
    HOLD_GRADE,
    DONE
  } state_t;

  localparam logic [2:0] COST      = 3'(GAME_COST);
  localparam logic [3:0] MAX_CRED4 = 4'(MAX_CREDIT);
  localparam logic [3:0] LAST_RND  = 4'(MAX_ROUNDS);

  state_t     state;
  logic [2:0] coin_worth;
  logic [3:0] credit_sum;
  logic [2:0] credit_sat;
  logic [3:0] round_next;

  // Coin code to credit worth: 00=0, 01=1, 10=3, 11=5.
  always_comb begin
    coin_worth = 3'd0;
    case (CoinValue)
      2'b01:   coin_worth = 3'd1;
      2'b10:   coin_worth = 3'd3;
      2'b11:   coin_worth = 3'd5;
      default: coin_worth = 3'd0;
    endcase
  end

  // One extra bit so the sum cannot wrap before the saturation compare.
  assign credit_sum = {1'b0, credits} + {1'b0, coin_worth};
  assign credit_sat = (credit_sum > MAX_CRED4) ? MAX_CRED4[2:0] : credit_sum[2:0];
  assign round_next = roundNum + 4'd1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= WAIT_COIN;
      credits    <= 3'd0;
      loadMaster <= 1'b0;
      gradeReq   <= 1'b0;
      roundNum   <= 4'd0;
      gameActive <= 1'b0;
      gameWon    <= 1'b0;
      gameLost   <= 1'b0;
    end else begin
      loadMaster <= 1'b0;
      case (state)
        WAIT_COIN: begin
          // Coin wins over a simultaneous start request.
          if (CoinInserted) begin
            credits <= credit_sat;
            state   <= HOLD_COIN;
          end else if (StartGame && (credits >= COST)) begin
            credits    <= credits - COST;
            loadMaster <= 1'b1;
            roundNum   <= 4'd0;
            gameWon    <= 1'b0;
            gameLost   <= 1'b0;
            gameActive <= 1'b1;
            state      <= LOAD;
          end
        end
        HOLD_COIN: begin
          if (!CoinInserted) state <= WAIT_COIN;
        end
        LOAD: begin
          state <= WAIT_GUESS;
        end
        WAIT_GUESS: begin
          if (GradeIt) begin
            gradeReq <= 1'b1;
            state    <= GRADING;
          end
        end
        GRADING: begin
          if (gradeDone) begin
            gradeReq <= 1'b0;
            roundNum <= round_next;
            if (numZnarly == 3'd4) begin
              gameWon    <= 1'b1;
              gameActive <= 1'b0;
              state      <= DONE;
            end else if (round_next == LAST_RND) begin
              gameLost   <= 1'b1;
              gameActive <= 1'b0;
              state      <= DONE;
            end else begin
              state <= HOLD_GRADE;
            end
          end
        end
        HOLD_GRADE: begin
          if (!GradeIt) state <= WAIT_GUESS;
        end
        DONE: begin
          if (!GradeIt && !StartGame) state <= WAIT_COIN;
        end
        default: begin
          state <= WAIT_COIN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
module tb_game_sequencer;
  localparam int GAME_COST  = 4;
  localparam int MAX_CREDIT = 7;
  localparam int MAX_ROUNDS = 8;

  logic       clock = 1'b0;
  logic       reset;
  logic       CoinInserted;
  logic [1:0] CoinValue;
  logic       StartGame;
  logic       GradeIt;
  logic       gradeDone;
  logic [2:0] numZnarly;
  logic [2:0] credits;
  logic       loadMaster;
  logic       gradeReq;
  logic [3:0] roundNum;
  logic       gameActive;
  logic       gameWon;
  logic       gameLost;

  always #5 clock = ~clock;

  game_sequencer #(
    .GAME_COST (GAME_COST),
    .MAX_CREDIT(MAX_CREDIT),
    .MAX_ROUNDS(MAX_ROUNDS)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .CoinInserted(CoinInserted),
    .CoinValue   (CoinValue),
    .StartGame   (StartGame),
    .GradeIt     (GradeIt),
    .gradeDone   (gradeDone),
    .numZnarly   (numZnarly),
    .credits     (credits),
    .loadMaster  (loadMaster),
    .gradeReq    (gradeReq),
    .roundNum    (roundNum),
    .gameActive  (gameActive),
    .gameWon     (gameWon),
    .gameLost    (gameLost)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: game bookkeeping as plain numbers.
  int m_credits = 0;
  int m_round   = 0;
  bit m_won     = 0;
  bit m_lost    = 0;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int coin_worth(input logic [1:0] v);
    case (v)
      2'b01:   return 1;
      2'b10:   return 3;
      2'b11:   return 5;
      default: return 0;
    endcase
  endfunction

  task automatic insert_coin(input logic [1:0] v, input int hold);
    CoinValue    = v;
    CoinInserted = 1'b1;
    step();
    m_credits = m_credits + coin_worth(v);
    if (m_credits > MAX_CREDIT) m_credits = MAX_CREDIT;
    check("coin_credit", credits, m_credits);
    repeat (hold) step();
    check("coin_hold_once", credits, m_credits);
    CoinInserted = 1'b0;
    CoinValue    = 2'b00;
    step();
  endtask

  task automatic start_game();
    StartGame = 1'b1;
    step();
    m_credits = m_credits - GAME_COST;
    m_round   = 0;
    m_won     = 0;
    m_lost    = 0;
    check("load_strobe", loadMaster, 1);
    check("load_active", gameActive, 1);
    check("load_credits", credits, m_credits);
    check("load_round", roundNum, 0);
    check("load_clear_result", {gameWon, gameLost}, 0);
    StartGame = 1'b0;
    step();
    check("load_one_cycle", loadMaster, 0);
    check("guess_active", gameActive, 1);
  endtask

  // One guess: request, optional wait for the grader, result, optional hold.
  task automatic do_grade(input logic [2:0] z, input int delay, input int hold,
                          input bit stray, output bit finished);
    if (stray) begin
      gradeDone = 1'b1;
      numZnarly = 3'd4;
      step();
      gradeDone = 1'b0;
      check("stray_done_round", roundNum, m_round);
      check("stray_done_won", gameWon, 0);
    end
    GradeIt = 1'b1;
    step();
    check("grade_req_rise", gradeReq, 1);
    for (int i = 0; i < delay; i++) begin
      CoinInserted = 1'($urandom_range(0, 1));
      CoinValue    = 2'b11;
      step();
      check("grade_req_hold", gradeReq, 1);
      check("coin_ignored", credits, m_credits);
    end
    CoinInserted = 1'b0;
    gradeDone    = 1'b1;
    numZnarly    = z;
    step();
    gradeDone = 1'b0;
    numZnarly = 3'd0;
    m_round++;
    if (z == 3'd4) m_won = 1;
    else if (m_round == MAX_ROUNDS) m_lost = 1;
    finished = m_won || m_lost;
    check("grade_req_drop", gradeReq, 0);
    check("grade_round", roundNum, m_round);
    check("grade_won", gameWon, m_won);
    check("grade_lost", gameLost, m_lost);
    check("grade_active", gameActive, !finished);
    for (int i = 0; i < hold; i++) begin
      step();
      check("held_no_regrade", gradeReq, 0);
      check("held_round", roundNum, m_round);
    end
    GradeIt = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit fin;
    reset        = 1'b1;
    CoinInserted = 1'b0;
    CoinValue    = 2'b00;
    StartGame    = 1'b0;
    GradeIt      = 1'b0;
    gradeDone    = 1'b0;
    numZnarly    = 3'd0;
    #3;
    check("reset_async", {credits, loadMaster, gradeReq, roundNum, gameActive, gameWon, gameLost}, 0);
    step();
    step();
    reset = 1'b0;
    step();
    check("reset_credits", credits, 0);
    check("reset_active", gameActive, 0);

    // Coin 11 held ten cycles twice: 5 then saturate at 7.
    insert_coin(2'b11, 10);
    insert_coin(2'b11, 10);

    // Win on the third guess.
    start_game();
    do_grade(3'd1, 1, 0, 1'b0, fin);
    do_grade(3'd0, 0, 2, 1'b1, fin);
    // Third guess: keep GradeIt high so the sequencer sits in DONE.
    GradeIt   = 1'b1;
    step();
    gradeDone = 1'b1;
    numZnarly = 3'd4;
    step();
    gradeDone = 1'b0;
    m_round++;
    m_won = 1;
    check("win_round", roundNum, 3);
    check("win_won", gameWon, 1);
    check("win_lost", gameLost, 0);
    // A coin offered while still in DONE earns nothing yet.
    CoinInserted = 1'b1;
    CoinValue    = 2'b01;
    repeat (3) step();
    check("done_coin_ignored", credits, m_credits);
    // Releasing GradeIt returns to WAIT_COIN, where the waiting coin counts.
    GradeIt = 1'b0;
    step();
    step();
    m_credits = m_credits + 1;
    check("late_coin_credit", credits, m_credits);
    CoinInserted = 1'b0;
    step();

    // Insufficient credit (4) ... first spend down to 3 is not possible, so
    // use the known state: credits 4 now. Priority check with a zero-value coin.
    CoinInserted = 1'b1;
    CoinValue    = 2'b00;
    StartGame    = 1'b1;
    step();
    check("prio_no_load", loadMaster, 0);
    check("prio_credits", credits, m_credits);
    CoinInserted = 1'b0;
    StartGame    = 1'b0;
    step();
    check("prio_still_idle", gameActive, 0);

    // Lose after eight grades, GradeIt held across each gradeDone.
    start_game();
    check("start_credits_zero", credits, 0);
    for (int r = 0; r < MAX_ROUNDS; r++) do_grade(3'd2, r % 3, 2, 1'b0, fin);
    check("lose_final", gameLost, 1);
    check("lose_rounds", roundNum, MAX_ROUNDS);

    // StartGame with 3 credits is ignored.
    insert_coin(2'b10, 0);
    StartGame = 1'b1;
    step();
    step();
    check("short_credit_no_load", loadMaster, 0);
    check("short_credit_keep", credits, 3);
    check("short_credit_idle", gameActive, 0);
    StartGame = 1'b0;
    step();

    // Randomized coins and games.
    for (int i = 0; i < 10; i++) insert_coin(2'($urandom_range(0, 3)), $urandom_range(0, 4));
    for (int g = 0; g < 6; g++) begin
      if (m_credits < GAME_COST) begin
        StartGame = 1'b1;
        step();
        StartGame = 1'b0;
        check("rand_short_no_load", loadMaster, 0);
        check("rand_short_credits", credits, m_credits);
        step();
      end
      for (int k = 0; k < 20 && m_credits < GAME_COST; k++)
        insert_coin(2'($urandom_range(0, 3)), $urandom_range(0, 3));
      if (m_credits < GAME_COST) insert_coin(2'b11, 0);
      start_game();
      fin = 0;
      for (int r = 0; r < MAX_ROUNDS && !fin; r++)
        do_grade(3'($urandom_range(0, 7)), $urandom_range(0, 3), $urandom_range(0, 3),
                 1'($urandom_range(0, 1)), fin);
      check("rand_game_over", fin, 1);
      check("rand_one_result", gameWon ^ gameLost, 1);
    end

    // Reset during GRADING takes effect without a clock edge.
    if (m_credits < GAME_COST) insert_coin(2'b11, 0);
    start_game();
    GradeIt = 1'b1;
    step();
    check("pre_reset_req", gradeReq, 1);
    GradeIt = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("mid_reset_req", gradeReq, 0);
    check("mid_reset_credits", credits, 0);
    check("mid_reset_all", {credits, loadMaster, gradeReq, roundNum, gameActive, gameWon, gameLost}, 0);
    step();
    reset = 1'b0;
    m_credits = 0;
    step();
    insert_coin(2'b01, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
